sprite_line_writer: RTL

- Sprite rasteriser back end. Writes 8-pixel sprite row slices into the scanline buffer's write port (wadr/wdat/we), reading back through rdat1.
- Resolves priority: the first-written opaque pixel wins. Colour 0 is transparent.
- Also clears a finished line-buffer bank before reuse.
- Sits between the sprite fetch/decode stage and the line buffer. The video scanout reads the other bank.

---
 rtl/sprite_line_writer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sprite_line_writer.sv
// Sprite row-slice writer for the scanline buffer: read-check-write per pixel, first opaque wins,
// plus a bank clear sweep. Optional collision flag under `SPRITE_COLLISION_EN.
module sprite_line_writer #(
   parameter int XLIM   = 256,
   parameter int CLRLEN = 512
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [8:0]  cmd_x,
   input  logic [31:0] cmd_pix,
   input  logic [6:0]  cmd_pal,
   input  logic        cmd_flip,
   input  logic        bank,
   input  logic        clr_req,
   input  logic        clr_bank,
   output logic        busy,
   output logic [9:0]  wadr,
   output logic [10:0] wdat,
   output logic        we,
   input  logic [10:0] rdat1,
   output logic        coll
);

   typedef enum logic [1:0] {IDLE, RD, WR, CLR} state_t;

   typedef struct packed {
      logic [8:0]  x;
      logic [31:0] pix;
      logic [6:0]  pal;
      logic        flip;
      logic        bank;
   } cmd_t;

   localparam logic [9:0] XLIM_W   = 10'(XLIM);
   localparam logic [8:0] CLR_LAST = 9'(CLRLEN - 1);

   state_t     state, state_n;
   cmd_t       cmd;
   logic [2:0] idx;
   logic [8:0] cnt;
   logic       clr_pend, clr_bank_q;
   logic [2:0] sel;
   logic [3:0] p;
   logic [8:0] px;
   logic       visible, under_clear, accept, clr_start, wr_ok;
   logic       unused_rd;

   assign unused_rd   = ^rdat1[10:4];
   assign sel         = cmd.flip ? (3'd7 - idx) : idx;
   assign p           = cmd.pix[{sel, 2'b00} +: 4];
   assign px          = cmd.x + 9'(idx);
   assign visible     = {1'b0, px} < XLIM_W;
   assign under_clear = (rdat1[3:0] == 4'd0);
   assign wr_ok       = (p != 4'd0) && visible && under_clear;

   assign cmd_ready = reset_n && (state == IDLE) && !clr_pend && !clr_req;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state != IDLE);
   assign clr_start = (state_n == CLR) && (state != CLR);

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (clr_req || clr_pend) state_n = CLR;
            else if (accept)         state_n = RD;
         end
         RD:  state_n = WR;
         WR: begin
            if (idx != 3'd7)             state_n = RD;
            else if (clr_pend || clr_req) state_n = CLR;
            else                         state_n = IDLE;
         end
         CLR: if (cnt == CLR_LAST) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Datapath registers: latched command, pixel index, clear counter and pending clear.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cmd        <= '0;
         idx        <= '0;
         cnt        <= '0;
         clr_pend   <= 1'b0;
         clr_bank_q <= 1'b0;
      end else begin
         if (accept) begin
            cmd <= '{x: cmd_x, pix: cmd_pix, pal: cmd_pal, flip: cmd_flip, bank: bank};
            idx <= '0;
         end else if (state == WR) begin
            idx <= idx + 3'd1;
         end
         if (clr_start) begin
            cnt      <= '0;
            clr_pend <= 1'b0;
         end else begin
            if (state == CLR) cnt <= cnt + 9'd1;
            if (clr_req && (state == RD || state == WR)) clr_pend <= 1'b1;
         end
         // A request arriving mid-sweep is ignored, so its bank must not overwrite the live one.
         if (clr_req && state != CLR) clr_bank_q <= clr_bank;
      end
   end

   always_comb begin
      wadr = '0;
      wdat = '0;
      we   = 1'b0;
      unique case (state)
         RD: wadr = {cmd.bank, px};
         WR: begin
            wadr = {cmd.bank, px};
            if (wr_ok) begin
               we   = 1'b1;
               wdat = {cmd.pal, p};
            end
         end
         CLR: begin
            wadr = {clr_bank_q, cnt};
            we   = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef SPRITE_COLLISION_EN
   logic coll_q;

   always_ff @(posedge clk) begin
      if (!reset_n)                                             coll_q <= 1'b0;
      else if (clr_start)                                       coll_q <= 1'b0;
      else if (state == WR && p != 4'd0 && visible && !under_clear) coll_q <= 1'b1;
   end

   assign coll = coll_q;
`else
   assign coll = 1'b0;
`endif

endmodule
